sha256_msg_padder: RTL and testbench

//  Upstream stage of sha256_transform. Packs a 32-bit byte stream into 512-bit SHA-256 blocks.

---
 rtl/sha256_pkg.sv | 47 ++++
 rtl/sha256_msg_padder_if.sv | 27 ++
 rtl/sha256_pad_word.sv | 29 ++
 rtl/sha256_msg_padder.sv | 157 +++++++++++++++
 tb/tb_sha256_msg_padder.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: widths, padding marker, IV, round constants
// and the message padder state encoding.
package sha256_pkg;

  localparam int SHA256_BLOCK_W = 512;
  localparam int SHA256_WORD_W  = 32;
  localparam int SHA256_LEN_W   = 64;

  localparam logic [31:0] SHA256_PAD_MARKER = 32'h8000_0000;

  localparam logic [31:0] SHA256_H0 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] SHA256_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {
    PAD_FILL  = 2'd0,
    PAD_PAD   = 2'd1,
    PAD_OUT   = 2'd2,
    PAD_EXTRA = 2'd3
  } pad_state_e;

  // Number of leading kept bytes in an MSB-first keep mask.
  function automatic logic [2:0] keep_bytes(input logic [3:0] keep);
    logic [2:0] n;
    casez (keep)
      4'b1111: n = 3'd4;
      4'b1110: n = 3'd3;
      4'b110?: n = 3'd2;
      4'b10??: n = 3'd1;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Byte-stream input and padded-block output of the SHA-256 message padder.
// A transfer happens on a rising clk edge where valid && ready; the source holds its payload
// stable while valid is high and ready is low, and ready never depends combinationally on valid.
interface sha256_msg_padder_if;
  import sha256_pkg::*;

  logic [SHA256_WORD_W-1:0]  s_tdata;
  logic [3:0]                s_tkeep;
  logic                      s_tlast;
  logic                      s_tvalid;
  logic                      s_tready;
  logic [SHA256_BLOCK_W-1:0] m_block;
  logic                      m_first;
  logic                      m_last;
  logic                      m_valid;
  logic                      m_ready;

  modport slave (
    input  s_tdata, s_tkeep, s_tlast, s_tvalid, m_ready,
    output s_tready, m_block, m_first, m_last, m_valid
  );

  modport master (
    output s_tdata, s_tkeep, s_tlast, s_tvalid, m_ready,
    input  s_tready, m_block, m_first, m_last, m_valid
  );
endinterface

// File: rtl/sha256_pad_word.sv
// Final-beat word shaping: clears unkept bytes and places the 0x80 marker
// right after the last kept byte, or flags that it belongs in the next word.
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [31:0] data,
  input  logic [3:0]  keep,
  output logic [31:0] word,
  output logic [2:0]  nbytes,
  output logic        marker_in_next
);

  always_comb begin
    nbytes         = keep_bytes(keep);
    word           = '0;
    marker_in_next = 1'b0;
    case (nbytes)
      3'd4: begin
        word           = data;
        marker_in_next = 1'b1;
      end
      3'd3:    word = {data[31:8], 8'h80};
      3'd2:    word = {data[31:16], 16'h8000};
      3'd1:    word = {data[31:24], 24'h80_0000};
      default: word = SHA256_PAD_MARKER;
    endcase
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// Packs a 32-bit byte stream into padded 512-bit SHA-256 blocks (0x80 marker,
// zero fill, 64-bit big-endian bit length), adding an extra block when the length does not fit.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  sha256_msg_padder_if.slave  bus,
  output pad_state_e          dbg_state
);

  pad_state_e        state;
  logic [31:0]       words [16];
  logic [3:0]        widx;
  logic [LEN_W-1:0]  byte_cnt;
  logic              first_pend;
  logic              extra_pend;
  logic              marker_pend;
  logic              fits;
  logic              s_tready_q;
  logic              m_valid_q;
  logic              m_first_q;
  logic              m_last_q;

  logic [31:0]       pw_word;
  logic [2:0]        pw_nbytes;
  logic              pw_next;
  logic              beat;
  logic [6:0]        blk_bytes;
  logic [LEN_W-1:0]  len_bits;
  logic [63:0]       msg_len;

  sha256_pad_word u_pad_word (
    .data           (bus.s_tdata),
    .keep           (bus.s_tkeep),
    .word           (pw_word),
    .nbytes         (pw_nbytes),
    .marker_in_next (pw_next)
  );

  assign beat      = bus.s_tvalid && s_tready_q;
  assign blk_bytes = {1'b0, widx, 2'b00} + 7'(pw_nbytes);
  assign len_bits  = byte_cnt << 3;
  assign msg_len   = 64'(len_bits);

  assign bus.s_tready = s_tready_q;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_first  = m_first_q;
  assign bus.m_last   = m_last_q;
  assign dbg_state    = state;

  for (genvar g = 0; g < 16; g++) begin : g_pack
    assign bus.m_block[32*g +: 32] = words[g];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PAD_FILL;
      words       <= '{default: '0};
      widx        <= '0;
      byte_cnt    <= '0;
      first_pend  <= 1'b1;
      extra_pend  <= 1'b0;
      marker_pend <= 1'b0;
      fits        <= 1'b0;
      s_tready_q  <= 1'b0;
      m_valid_q   <= 1'b0;
      m_first_q   <= 1'b0;
      m_last_q    <= 1'b0;
    end else begin
      case (state)
        PAD_FILL: begin
          s_tready_q <= 1'b1;
          if (beat) begin
            byte_cnt <= byte_cnt + LEN_W'(bus.s_tlast ? pw_nbytes : 3'd4);
            if (!bus.s_tlast) begin
              words[widx] <= bus.s_tdata;
              if (widx == 4'd15) begin
                state      <= PAD_OUT;
                s_tready_q <= 1'b0;
                m_valid_q  <= 1'b1;
                m_first_q  <= first_pend;
                m_last_q   <= 1'b0;
              end else begin
                widx <= widx + 4'd1;
              end
            end else begin
              // widx is left on the word holding the marker so PAD can clear everything above it.
              words[widx] <= pw_word;
              fits        <= (blk_bytes <= 7'd55);
              state       <= PAD_PAD;
              s_tready_q  <= 1'b0;
              if (pw_next) begin
                if (widx == 4'd15) begin
                  marker_pend <= 1'b1;
                end else begin
                  words[widx + 4'd1] <= SHA256_PAD_MARKER;
                  widx               <= widx + 4'd1;
                end
              end
            end
          end
        end

        PAD_PAD: begin
          for (int t = 0; t < 16; t++) begin
            if (4'(t) > widx) words[t] <= '0;
          end
          if (fits) begin
            words[14] <= msg_len[63:32];
            words[15] <= msg_len[31:0];
            m_last_q  <= 1'b1;
          end else begin
            extra_pend <= 1'b1;
            m_last_q   <= 1'b0;
          end
          m_valid_q <= 1'b1;
          m_first_q <= first_pend;
          state     <= PAD_OUT;
        end

        PAD_OUT: begin
          if (bus.m_ready) begin
            m_valid_q  <= 1'b0;
            first_pend <= m_last_q;
            if (extra_pend) begin
              state <= PAD_EXTRA;
            end else begin
              widx       <= '0;
              state      <= PAD_FILL;
              s_tready_q <= 1'b1;
              if (m_last_q) byte_cnt <= '0;
            end
          end
        end

        PAD_EXTRA: begin
          for (int t = 0; t < 16; t++) words[t] <= '0;
          words[0]    <= marker_pend ? SHA256_PAD_MARKER : 32'h0;
          words[14]   <= msg_len[63:32];
          words[15]   <= msg_len[31:0];
          extra_pend  <= 1'b0;
          marker_pend <= 1'b0;
          m_valid_q   <= 1'b1;
          m_first_q   <= first_pend;
          m_last_q    <= 1'b1;
          state       <= PAD_OUT;
        end

        default: state <= PAD_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: directed vectors plus random messages checked
// against a byte-queue padding model; randomized output backpressure.
module tb_sha256_msg_padder;
  import sha256_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  pad_state_e dbg_state;
  int         total = 0;
  int         bad = 0;
  bit         hold = 1'b1;

  logic [513:0] exp_q[$];
  logic [7:0]   msg_q[$];
  logic [513:0] exp_e;
  logic [511:0] cap_blk;
  logic [511:0] lit_blk;

  sha256_msg_padder_if bus();

  sha256_msg_padder #(.LEN_W(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic report();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  // random output backpressure
  initial begin
    bus.m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.m_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // scoreboard: each block handshake is compared with the head of exp_q
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.m_valid && bus.m_ready) begin
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_block got a block, want none");
        end
        if (exp_q.size() != 0) begin
          exp_e = exp_q.pop_front();
          chk("blk_data",  bus.m_block, exp_e[511:0]);
          chk("blk_first", 512'(bus.m_first), 512'(exp_e[513]));
          chk("blk_last",  512'(bus.m_last),  512'(exp_e[512]));
        end
      end
    end
  end

  // reference: append 0x80, zero-fill to 56 mod 64, append 64-bit bit count, cut into blocks
  task automatic model_push();
    logic [7:0]   p[$];
    logic [63:0]  bits;
    logic [511:0] blk;
    int           nblk;
    p = msg_q;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(msg_q.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nblk = p.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      blk = '0;
      for (int t = 0; t < 16; t++)
        blk[32*t +: 32] = {p[64*b+4*t], p[64*b+4*t+1], p[64*b+4*t+2], p[64*b+4*t+3]};
      exp_q.push_back({1'(b == 0), 1'(b == nblk - 1), blk});
    end
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n;
    bus.s_tdata  = d;
    bus.s_tkeep  = k;
    bus.s_tlast  = l;
    bus.s_tvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.s_tready && n < 2000);
    total++;
    assert (bus.s_tready === 1'b1) else begin
      bad++;
      $error("FAIL beat_accept got s_tready=%b after %0d cycles, want 1", bus.s_tready, n);
      report();
    end
    @(posedge clk);
    #1;
    bus.s_tvalid = 1'b0;
  endtask

  // drives msg_q as beats; unkept bytes and non-last keep masks carry junk
  task automatic drive_msg();
    int          nb, nbeats, r;
    logic [31:0] w;
    logic [3:0]  k;
    nb = msg_q.size();
    if (nb == 0) begin
      drive_beat($urandom, 4'b0000, 1'b1);
    end else begin
      nbeats = (nb + 3) / 4;
      for (int b = 0; b < nbeats; b++) begin
        w = $urandom;
        for (int i = 0; i < 4; i++)
          if (4*b + i < nb) w[31-8*i -: 8] = msg_q[4*b+i];
        r = nb - 4*b;
        if (b == nbeats - 1)
          k = (r >= 4) ? 4'b1111 : (r == 3) ? 4'b1110 : (r == 2) ? 4'b1100 : 4'b1000;
        else
          k = 4'($urandom);
        drive_beat(w, k, 1'(b == nbeats - 1));
      end
    end
  endtask

  task automatic rand_msg(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom_range(0, 255)));
    model_push();
    drive_msg();
  endtask

  task automatic send_abc();
    msg_q.delete();
    msg_q.push_back(8'h61);
    msg_q.push_back(8'h62);
    msg_q.push_back(8'h63);
    lit_blk = '0;
    lit_blk[31:0] = 32'h6162_6380;
    lit_blk[32*15 +: 32] = 32'h0000_0018;
    exp_q.push_back({1'b1, 1'b1, lit_blk});
    drive_msg();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL drain got %0d blocks outstanding, want 0", exp_q.size());
      report();
    end
  endtask

  initial begin
    int n;
    bus.s_tdata  = '0;
    bus.s_tkeep  = '0;
    bus.s_tlast  = 1'b0;
    bus.s_tvalid = 1'b0;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_m_valid",  512'(bus.m_valid),  512'(0));
    chk("rst_s_tready", 512'(bus.s_tready), 512'(0));
    chk("rst_m_first",  512'(bus.m_first),  512'(0));
    chk("rst_m_last",   512'(bus.m_last),   512'(0));
    chk("rst_m_block",  bus.m_block, 512'(0));
    rst_n = 1'b1;
    hold  = 1'b0;

    // "abc"
    send_abc();

    // empty message
    msg_q.delete();
    lit_blk = '0;
    lit_blk[31:0] = 32'h8000_0000;
    exp_q.push_back({1'b1, 1'b1, lit_blk});
    drive_msg();

    // 55 / 56 / 64 byte boundaries and their neighbours
    rand_msg(55);
    rand_msg(56);
    rand_msg(64);
    for (int len = 52; len <= 68; len += 4) rand_msg(len + int'($urandom_range(0, 3)));
    repeat (12) rand_msg(int'($urandom_range(0, 150)));
    drain();

    // output held off for 10 cycles: block stable, input stalled
    hold = 1'b1;
    rand_msg(20);
    n = 0;
    while (!bus.m_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_wait_valid", 512'(bus.m_valid), 512'(1));
    if (!bus.m_valid) report();
    cap_blk = bus.m_block;
    repeat (10) begin
      @(negedge clk);
      chk("bp_block",    bus.m_block, cap_blk);
      chk("bp_valid",    512'(bus.m_valid),  512'(1));
      chk("bp_s_tready", 512'(bus.s_tready), 512'(0));
    end
    hold = 1'b0;

    // reset mid-message discards the partial message
    for (int i = 0; i < 5; i++) drive_beat($urandom, 4'($urandom), 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m_valid",  512'(bus.m_valid),  512'(0));
    chk("mid_rst_s_tready", 512'(bus.s_tready), 512'(0));
    chk("mid_rst_queue",    512'(exp_q.size()), 512'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_abc();
    drain();

    report();
  end

endmodule
